// File: rtl/ch_scheduler_if.sv
// ch_scheduler_if
// Groups the request/grant signals of the round-robin channel scheduler.
//   master : request side (drives en_i, req_i, done_i, timeout_i;
//            observes grant_o, grant_idx_o, busy_o, timeout_o, pending_o)
//   slave  : the scheduler itself
`timescale 1ns/1ps
interface ch_scheduler_if #(
    parameter int N_CH      = 16,
    parameter int TIMEOUT_W = 8
);
    localparam int IDX_W = $clog2(N_CH);

    logic                 en_i;
    logic [N_CH-1:0]      req_i;
    logic                 done_i;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic [N_CH-1:0]      grant_o;
    logic [IDX_W-1:0]     grant_idx_o;
    logic                 busy_o;
    logic                 timeout_o;
    logic [N_CH-1:0]      pending_o;

    modport master (
        output en_i, req_i, done_i, timeout_i,
        input  grant_o, grant_idx_o, busy_o, timeout_o, pending_o
    );

    modport slave (
        input  en_i, req_i, done_i, timeout_i,
        output grant_o, grant_idx_o, busy_o, timeout_o, pending_o
    );
endinterface

// File: rtl/ch_scheduler.sv
// ch_scheduler
// Shares one downstream slot among N_CH channels. Requests are latched into a
// pending register; one channel at a time is granted (one-hot + index) until
// the consumer signals done or the latched timeout expires, then the search
// restarts just above the released channel so every requester is served.
//
// Ports:
//   clk_i     system clock, rising edge
//   resetn_i  asynchronous active-low reset
//   bus       ch_scheduler_if.slave (en/req/done/timeout in,
//             grant/grant_idx/busy/timeout pulse/pending out)
//
// Build option: define CH_SCHED_FIXED_PRIO_EN for fixed priority
// (lowest pending index wins) instead of round-robin.
//
// state   | meaning
// IDLE    | no grant held; arbitrate when enabled and something is pending
// BUSY    | grant held; wait for done or timeout
// RELEASE | grant dropped; clear released pending bit, update last_idx
`timescale 1ns/1ps
module ch_scheduler #(
    parameter int N_CH      = 16,
    parameter int TIMEOUT_W = 8
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    ch_scheduler_if.slave    bus
);
    localparam int IDX_W = $clog2(N_CH);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t               state_q, state_d;
    logic [N_CH-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 pulse_q, pulse_d;
    logic [N_CH-1:0]      pend_q, pend_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    logic [N_CH-1:0]      cand;
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     probe;

    // Requests arriving this cycle are eligible immediately, not only after
    // they land in the pending register.
    always_comb begin
        cand    = pend_q | bus.req_i;
        found   = 1'b0;
        win_idx = '0;
        probe   = '0;
`ifdef CH_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < N_CH; i++) begin
            probe = IDX_W'(i);
            if (!found && cand[probe]) begin
                found   = 1'b1;
                win_idx = probe;
            end
        end
`else
        // Index arithmetic wraps naturally because N_CH is a power of two.
        for (int i = 0; i < N_CH; i++) begin
            probe = last_q + IDX_W'(i + 1);
            if (!found && cand[probe]) begin
                found   = 1'b1;
                win_idx = probe;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        pulse_d = 1'b0;
        pend_d  = pend_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.en_i && found) begin
                    state_d = BUSY;
                    grant_d = N_CH'(1) << win_idx;
                    idx_d   = win_idx;
                    busy_d  = 1'b1;
                    tmo_d   = bus.timeout_i;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);
                if (bus.done_i) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if (tmo_q != '0 && cnt_q == tmo_q - TIMEOUT_W'(1)) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    pulse_d = 1'b1;
                end
            end
            RELEASE: begin
                state_d        = IDLE;
                last_d         = idx_q;
                pend_d[idx_q]  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Capture after the release clear so a same-cycle re-request wins.
        if (bus.en_i) pend_d = pend_d | bus.req_i;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= '0;
            last_q  <= IDX_W'(N_CH - 1);
            tmo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant_o     = grant_q;
    assign bus.grant_idx_o = idx_q;
    assign bus.busy_o      = busy_q;
    assign bus.timeout_o   = pulse_q;
    assign bus.pending_o   = pend_q;
endmodule

// File: tb/tb_ch_scheduler.sv
`timescale 1ns/1ps
module tb_ch_scheduler;
    localparam int N_CH      = 16;
    localparam int TIMEOUT_W = 8;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ch_scheduler_if #(.N_CH(N_CH), .TIMEOUT_W(TIMEOUT_W)) bus ();

    ch_scheduler #(.N_CH(N_CH), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (bus)
    );

    // Expected grant: index, length in cycles (0 = don't care),
    // low cycles since previous grant (0 = don't care), timeout pulse at end.
    typedef struct {
        int idx;
        int len;
        int gap;
        bit tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input int idx, input int len, input int gap, input bit tmo);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.gap = gap;
        e.tmo = tmo;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor
    bit   in_grant = 1'b0;
    bit   have_cur = 1'b0;
    int   len_cnt  = 0;
    int   gap_cnt  = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!resetn) begin
            in_grant = 1'b0;
            have_cur = 1'b0;
            len_cnt  = 0;
            gap_cnt  = 0;
        end else if (bus.busy_o && !in_grant) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                have_cur = 1'b0;
                $display("FAIL unexpected_grant: got idx %0d, expected no grant", bus.grant_idx_o);
            end else begin
                cur      = exp_q.pop_front();
                have_cur = 1'b1;
                check("grant_idx", 32'(bus.grant_idx_o), 32'(cur.idx));
                check("grant_onehot", 32'(bus.grant_o), 32'(1) << cur.idx);
                if (cur.gap != 0) check("grant_gap", 32'(gap_cnt), 32'(cur.gap));
            end
            in_grant = 1'b1;
            len_cnt  = 1;
        end else if (bus.busy_o) begin
            len_cnt++;
        end else if (in_grant) begin
            in_grant = 1'b0;
            gap_cnt  = 1;
            if (have_cur) begin
                if (cur.len != 0) check("grant_len", 32'(len_cnt), 32'(cur.len));
                check("timeout_pulse", 32'(bus.timeout_o), 32'(cur.tmo));
            end
        end else begin
            gap_cnt++;
            if (bus.timeout_o) begin
                checks++;
                errors++;
                $display("FAIL stray_timeout: got timeout_o=1, expected 0");
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input bit lvl, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (bus.busy_o === lvl) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: busy_o never reached %0d, expected within 100 cycles", name, lvl);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en_i      = 1'b0;
        bus.req_i     = '0;
        bus.done_i    = 1'b0;
        bus.timeout_i = '0;
        cyc(2);
        check("rst_grant",     32'(bus.grant_o),     32'h0);
        check("rst_grant_idx", 32'(bus.grant_idx_o), 32'h0);
        check("rst_busy",      32'(bus.busy_o),      32'h0);
        check("rst_timeout",   32'(bus.timeout_o),   32'h0);
        check("rst_pending",   32'(bus.pending_o),   32'h0);
        resetn = 1'b1;

        // Round-robin (or fixed priority) with req 0x0011 held.
        bus.en_i  = 1'b1;
        bus.req_i = 16'h0011;
`ifdef CH_SCHED_FIXED_PRIO_EN
        exp_q.push_back(mk(0, 1, 0, 1'b0));
        exp_q.push_back(mk(0, 1, 2, 1'b0));
        exp_q.push_back(mk(0, 1, 2, 1'b0));
        exp_q.push_back(mk(0, 1, 2, 1'b0));
`else
        exp_q.push_back(mk(0, 1, 0, 1'b0));
        exp_q.push_back(mk(4, 1, 2, 1'b0));
        exp_q.push_back(mk(0, 1, 2, 1'b0));
        exp_q.push_back(mk(4, 1, 2, 1'b0));
`endif
        for (int i = 0; i < 4; i++) begin
            wait_busy(1'b1, "rr_grant");
            bus.done_i = 1'b1;
            if (i == 3) begin
                bus.en_i  = 1'b0;
                bus.req_i = '0;
            end
            cyc(1);
            bus.done_i = 1'b0;
        end
        cyc(3);
        check("en_low_blocks_grant", 32'(bus.busy_o), 32'h0);
`ifdef CH_SCHED_FIXED_PRIO_EN
        check("rr_pending_left", 32'(bus.pending_o), 32'h0010);
`else
        check("rr_pending_left", 32'(bus.pending_o), 32'h0001);
`endif
        do_reset();

        // Async reset while ch 5 is granted.
        bus.en_i      = 1'b1;
        bus.req_i     = 16'h0020;
        exp_q.push_back(mk(5, 0, 0, 1'b0));
        wait_busy(1'b1, "ch5_grant");
        bus.req_i = '0;
        cyc(2);
        resetn = 1'b0;
        #1;
        check("async_rst_grant",   32'(bus.grant_o),   32'h0);
        check("async_rst_busy",    32'(bus.busy_o),    32'h0);
        check("async_rst_pending", 32'(bus.pending_o), 32'h0);
        cyc(2);
        resetn    = 1'b1;
        bus.req_i = 16'h0021;
        exp_q.push_back(mk(0, 1, 0, 1'b0));
        exp_q.push_back(mk(5, 1, 2, 1'b0));
        cyc(1);
        bus.req_i = '0;
        check("post_rst_pending", 32'(bus.pending_o), 32'h0021);
        bus.done_i = 1'b1;
        cyc(1);
        bus.done_i = 1'b0;
        wait_busy(1'b1, "ch5_after_rst");
        bus.done_i = 1'b1;
        cyc(1);
        bus.done_i = 1'b0;
        cyc(3);
        check("post_rst_pending_clear", 32'(bus.pending_o), 32'h0);

        // Single-cycle pulse captured while another channel is granted.
        exp_q.push_back(mk(2, 0, 0, 1'b0));
        exp_q.push_back(mk(8, 0, 2, 1'b0));
        bus.req_i = 16'h0004;
        cyc(1);
        bus.req_i = '0;
        cyc(1);
        bus.req_i = 16'h0100;
        cyc(1);
        bus.req_i = '0;
        check("pulse_pending", 32'(bus.pending_o), 32'h0104);
        bus.done_i = 1'b1;
        cyc(1);
        bus.done_i = 1'b0;
        wait_busy(1'b1, "ch8_grant");
        check("ch8_pending", 32'(bus.pending_o), 32'h0100);
        bus.done_i = 1'b1;
        cyc(1);
        bus.done_i = 1'b0;
        cyc(1);
        check("ch8_pending_clear", 32'(bus.pending_o), 32'h0);

        // Timeout of 4 cycles; mid-grant timeout_i change ignored.
        bus.timeout_i = 8'd4;
        exp_q.push_back(mk(2, 4, 0, 1'b1));
        exp_q.push_back(mk(3, 4, 2, 1'b1));
        bus.req_i = 16'h000C;
        cyc(1);
        bus.req_i = '0;
        wait_busy(1'b0, "ch2_timeout");
        wait_busy(1'b1, "ch3_grant");
        bus.timeout_i = 8'd1;
        wait_busy(1'b0, "ch3_timeout");
        cyc(2);
        check("tmo_pending_clear", 32'(bus.pending_o), 32'h0);

        // done_i and timeout in the same cycle; re-request during release.
        bus.timeout_i = 8'd2;
        exp_q.push_back(mk(6, 2, 0, 1'b0));
        exp_q.push_back(mk(6, 2, 2, 1'b1));
        bus.req_i = 16'h0040;
        cyc(1);
        bus.req_i = '0;
        cyc(1);
        bus.done_i = 1'b1;
        cyc(1);
        bus.done_i = 1'b0;
        bus.req_i  = 16'h0040;
        cyc(1);
        bus.req_i = '0;
        check("rerequest_pending_kept", 32'(bus.pending_o), 32'h0040);
        wait_busy(1'b1, "ch6_regrant");
        wait_busy(1'b0, "ch6_timeout");
        cyc(2);
        check("final_pending_clear", 32'(bus.pending_o), 32'h0);

        cyc(3);
        check("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
